// File: rtl/selfcomp_pkg.sv
// rtl/selfcomp_pkg.sv - shared types and defaults for the self-composition leak monitor
package selfcomp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DEFAULT_DATA_W  = 128;
   localparam int DEFAULT_CNT_W   = 16;
   localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/selfcomp_lat_capture.sv
// rtl/selfcomp_lat_capture.sv - per-copy first-valid latency latch
module selfcomp_lat_capture
   import selfcomp_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             valid,
   input  logic [CNT_W-1:0] cnt,
   output logic             hit,
   output logic             done,
   output logic [CNT_W-1:0] lat
);

   // Only the first valid of a transaction counts; later drops or re-raises are ignored.
   assign hit = enable & valid & ~done;

   // Latch the cycle count on the first valid, rearm at each launch.
   always_ff @(posedge clock) begin
      if (reset) begin
         done <= 1'b0;
         lat  <= '0;
      end else if (clear) begin
         done <= 1'b0;
      end else if (hit) begin
         done <= 1'b1;
         lat  <= cnt;
      end
   end

endmodule

// File: rtl/selfcomp_leak_monitor.sv
// rtl/selfcomp_leak_monitor.sv - latency skew and result divergence checker for two lock-step copies
module selfcomp_leak_monitor
   import selfcomp_pkg::*;
#(
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int CNT_W   = DEFAULT_CNT_W,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_fire,
   input  logic              valid_one,
   input  logic              valid_two,
   input  logic [DATA_W-1:0] result_one,
   input  logic [DATA_W-1:0] result_two,
   output logic              out_ready,
   output logic              both_valid,
   output logic              timing_leak,
   output logic              result_leak,
   output logic              timeout_err,
   output logic              protocol_err,
   output logic              timing_leak_done,
   output logic [CNT_W-1:0]  lat_one,
   output logic [CNT_W-1:0]  lat_two,
   output logic [CNT_W-1:0]  txn_count
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             launch;
   logic             run;
   logic             hit_one;
   logic             hit_two;
   logic             done_one;
   logic             done_two;
   logic             done_one_n;
   logic             done_two_n;

   assign launch     = in_fire & (state == IDLE);
   assign run        = (state == RUN);
   assign both_valid = valid_one & valid_two;
   // Drain only when both copies offer a result, so their handshakes stay aligned.
   assign out_ready  = (state == DRAIN) & both_valid;
   assign done_one_n = done_one | hit_one;
   assign done_two_n = done_two | hit_two;

   selfcomp_lat_capture #(.CNT_W(CNT_W)) u_cap_one (
      .clock  (clock),
      .reset  (reset),
      .clear  (launch),
      .enable (run),
      .valid  (valid_one),
      .cnt    (cnt),
      .hit    (hit_one),
      .done   (done_one),
      .lat    (lat_one)
   );

   selfcomp_lat_capture #(.CNT_W(CNT_W)) u_cap_two (
      .clock  (clock),
      .reset  (reset),
      .clear  (launch),
      .enable (run),
      .valid  (valid_two),
      .cnt    (cnt),
      .hit    (hit_two),
      .done   (done_two),
      .lat    (lat_two)
   );

   // Transaction FSM with latency counter, drain compare and sticky verdict flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= IDLE;
         cnt              <= '0;
         timing_leak      <= 1'b0;
         result_leak      <= 1'b0;
         timeout_err      <= 1'b0;
         protocol_err     <= 1'b0;
         timing_leak_done <= 1'b0;
         txn_count        <= '0;
      end else begin
         timing_leak_done <= 1'b0;
         if (in_fire && state != IDLE) begin
            protocol_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (in_fire) begin
                  state <= RUN;
                  cnt   <= CNT_W'(1);
               end
            end
            RUN: begin
               if (cnt != '1) begin
                  cnt <= cnt + CNT_W'(1);
               end
               if (done_one_n && done_two_n) begin
                  state <= DRAIN;
               end else if (cnt == TIMEOUT_C) begin
                  state            <= IDLE;
                  timeout_err      <= 1'b1;
                  timing_leak_done <= 1'b1;
                  if (done_one_n ^ done_two_n) begin
                     timing_leak <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (both_valid) begin
                  if (lat_one != lat_two) begin
                     timing_leak <= 1'b1;
                  end
                  if (result_one != result_two) begin
                     result_leak <= 1'b1;
                  end
                  if (txn_count != '1) begin
                     txn_count <= txn_count + CNT_W'(1);
                  end
                  timing_leak_done <= 1'b1;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_selfcomp_leak_monitor.sv
// tb/tb_selfcomp_leak_monitor.sv - randomized self-checking bench for selfcomp_leak_monitor
module tb_selfcomp_leak_monitor;

   localparam int DW    = 128;
   localparam int CW    = 16;
   localparam int TO    = 8;
   localparam int NEVER = 99;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_fire = 1'b0;
   logic          valid_one = 1'b0;
   logic          valid_two = 1'b0;
   logic [DW-1:0] result_one = '0;
   logic [DW-1:0] result_two = '0;
   logic          out_ready;
   logic          both_valid;
   logic          timing_leak;
   logic          result_leak;
   logic          timeout_err;
   logic          protocol_err;
   logic          timing_leak_done;
   logic [CW-1:0] lat_one;
   logic [CW-1:0] lat_two;
   logic [CW-1:0] txn_count;

   int checks = 0;
   int failures = 0;

   // reference model state
   bit m_tl, m_rl, m_te, m_pe;
   int m_txn, m_l1, m_l2;
   int e_or_cnt, e_or_first, e_done;

   // observations from one transaction
   int o_or_cnt, o_or_first, o_done, o_bv_bad;

   selfcomp_leak_monitor #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .clock            (clock),
      .reset            (reset),
      .in_fire          (in_fire),
      .valid_one        (valid_one),
      .valid_two        (valid_two),
      .result_one       (result_one),
      .result_two       (result_two),
      .out_ready        (out_ready),
      .both_valid       (both_valid),
      .timing_leak      (timing_leak),
      .result_leak      (result_leak),
      .timeout_err      (timeout_err),
      .protocol_err     (protocol_err),
      .timing_leak_done (timing_leak_done),
      .lat_one          (lat_one),
      .lat_two          (lat_two),
      .txn_count        (txn_count)
   );

   always #5 clock = ~clock;

   task automatic model_reset();
      m_tl = 0; m_rl = 0; m_te = 0; m_pe = 0;
      m_txn = 0; m_l1 = 0; m_l2 = 0;
   endtask

   // Transaction outcome from latencies a/b (NEVER = no valid), results, and stray fire.
   task automatic model_txn(input int a, input int b, input logic [DW-1:0] r1,
                            input logic [DW-1:0] r2, input int fire_at);
      int m;
      m = (a > b) ? a : b;
      if (fire_at > 0) m_pe = 1;
      if (m <= TO) begin
         m_l1 = a; m_l2 = b;
         if (a != b) m_tl = 1;
         if (r1 != r2) m_rl = 1;
         m_txn++;
         e_or_cnt = 1; e_or_first = m + 1; e_done = m + 2;
      end else begin
         m_te = 1;
         if (a <= TO) m_l1 = a;
         if (b <= TO) m_l2 = b;
         if ((a <= TO) != (b <= TO)) m_tl = 1;
         e_or_cnt = 0; e_or_first = -1; e_done = TO + 1;
      end
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset = 1'b1; in_fire = 1'b0; valid_one = 1'b0; valid_two = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   // Launch one transaction; each copy raises valid at its latency and holds it until drained.
   task automatic drive_txn(input int a, input int b, input logic [DW-1:0] r1,
                            input logic [DW-1:0] r2, input int fire_at);
      bit hs;
      @(negedge clock);
      in_fire = 1'b1; valid_one = 1'b0; valid_two = 1'b0;
      result_one = r1; result_two = r2;
      o_or_cnt = 0; o_or_first = -1; o_done = -1; o_bv_bad = 0; hs = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         in_fire   = (k == fire_at);
         valid_one = !hs && (k >= a);
         valid_two = !hs && (k >= b);
         #1;
         if (both_valid !== (valid_one & valid_two)) o_bv_bad++;
         if (timing_leak_done === 1'b1) begin
            o_done = k;
            break;
         end
         if (out_ready === 1'b1) begin
            o_or_cnt++;
            if (o_or_first < 0) o_or_first = k;
            hs = 1;
         end
      end
      @(negedge clock);
      in_fire = 1'b0; valid_one = 1'b0; valid_two = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++;
      if ({out_ready, timing_leak, result_leak, timeout_err, protocol_err, timing_leak_done} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {out_ready, timing_leak, result_leak, timeout_err, protocol_err, timing_leak_done});
      end
      checks++;
      if ({lat_one, lat_two, txn_count} !== '0) begin
         failures++;
         $display("FAIL reset_counters: got lat %0d/%0d txn %0d expected 0/0/0", lat_one, lat_two, txn_count);
      end
   endtask

   task automatic test_equal_latency();
      logic [DW-1:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      model_txn(3, 3, r, r, 0);
      drive_txn(3, 3, r, r, 0);
      checks++;
      if (lat_one !== 16'd3 || lat_two !== 16'd3) begin
         failures++;
         $display("FAIL eq_lat: got %0d/%0d expected 3/3", lat_one, lat_two);
      end
      checks++;
      if (o_or_cnt != 1 || o_or_first != 4) begin
         failures++;
         $display("FAIL eq_out_ready: got %0d cycles first %0d expected 1 first 4", o_or_cnt, o_or_first);
      end
      checks++;
      if (o_done != 5) begin
         failures++;
         $display("FAIL eq_done: got cycle %0d expected 5", o_done);
      end
      checks++;
      if (timing_leak !== 1'b0 || result_leak !== 1'b0 || txn_count !== 16'd1) begin
         failures++;
         $display("FAIL eq_verdict: got tl=%b rl=%b txn=%0d expected 0 0 1", timing_leak, result_leak, txn_count);
      end
   endtask

   task automatic test_skew();
      logic [DW-1:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      model_txn(3, 5, r, r, 0);
      drive_txn(3, 5, r, r, 0);
      checks++;
      if (lat_one !== 16'd3 || lat_two !== 16'd5) begin
         failures++;
         $display("FAIL skew_lat: got %0d/%0d expected 3/5", lat_one, lat_two);
      end
      checks++;
      if (o_or_cnt != 1 || o_or_first != 6) begin
         failures++;
         $display("FAIL skew_out_ready: got %0d cycles first %0d expected 1 first 6", o_or_cnt, o_or_first);
      end
      checks++;
      if (timing_leak !== 1'b1 || result_leak !== 1'b0) begin
         failures++;
         $display("FAIL skew_verdict: got tl=%b rl=%b expected 1 0", timing_leak, result_leak);
      end
   endtask

   task automatic test_result_diverge();
      apply_reset();
      model_txn(4, 4, 128'h1, 128'h2, 0);
      drive_txn(4, 4, 128'h1, 128'h2, 0);
      checks++;
      if (result_leak !== 1'b1 || timing_leak !== 1'b0) begin
         failures++;
         $display("FAIL diverge_verdict: got rl=%b tl=%b expected 1 0", result_leak, timing_leak);
      end
      checks++;
      if (lat_one !== 16'd4 || lat_two !== 16'd4 || o_done != 6) begin
         failures++;
         $display("FAIL diverge_lat: got %0d/%0d done %0d expected 4/4 done 6", lat_one, lat_two, o_done);
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      model_txn(3, NEVER, 128'h5, 128'h5, 0);
      drive_txn(3, NEVER, 128'h5, 128'h5, 0);
      checks++;
      if (timeout_err !== 1'b1 || timing_leak !== 1'b1) begin
         failures++;
         $display("FAIL timeout_flags: got te=%b tl=%b expected 1 1", timeout_err, timing_leak);
      end
      checks++;
      if (o_done != TO + 1 || o_or_cnt != 0) begin
         failures++;
         $display("FAIL timeout_timing: got done %0d out_ready %0d expected done %0d out_ready 0",
                  o_done, o_or_cnt, TO + 1);
      end
      checks++;
      if (txn_count !== 16'd0 || lat_one !== 16'd3) begin
         failures++;
         $display("FAIL timeout_counts: got txn %0d lat_one %0d expected 0 3", txn_count, lat_one);
      end
   endtask

   task automatic test_protocol_err();
      model_txn(3, 4, 128'h7, 128'h7, 2);
      drive_txn(3, 4, 128'h7, 128'h7, 2);
      checks++;
      if (protocol_err !== 1'b1) begin
         failures++;
         $display("FAIL proto_flag: got %b expected 1", protocol_err);
      end
      checks++;
      if (lat_one !== 16'd3 || lat_two !== 16'd4 || txn_count !== 16'(m_txn)) begin
         failures++;
         $display("FAIL proto_lat: got %0d/%0d txn %0d expected 3/4 txn %0d", lat_one, lat_two, txn_count, m_txn);
      end
   endtask

   task automatic test_reset_in_drain();
      @(negedge clock);
      in_fire = 1'b1; result_one = 128'h9; result_two = 128'h9;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         in_fire = 1'b0;
         valid_one = (k >= 3);
         valid_two = (k >= 3);
      end
      #1;
      checks++;
      if (out_ready !== 1'b1) begin
         failures++;
         $display("FAIL drain_ready: got %b expected 1", out_ready);
      end
      reset = 1'b1;
      @(negedge clock);
      #1;
      checks++;
      if ({out_ready, timing_leak, result_leak, timeout_err, protocol_err, timing_leak_done} !== 6'b0 ||
          {lat_one, lat_two, txn_count} !== '0) begin
         failures++;
         $display("FAIL drain_reset: got flags %b lat %0d/%0d txn %0d expected all 0",
                  {out_ready, timing_leak, result_leak, timeout_err, protocol_err, timing_leak_done},
                  lat_one, lat_two, txn_count);
      end
      reset = 1'b0; valid_one = 1'b0; valid_two = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      int a, b, m, lim, fire_at;
      logic [DW-1:0] r1, r2;
      for (int t = 0; t < 30; t++) begin
         a = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 10));
         b = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 10));
         r1 = {$urandom, $urandom, $urandom, $urandom};
         r2 = $urandom_range(0, 1) ? r1 : {$urandom, $urandom, $urandom, $urandom};
         m = (a > b) ? a : b;
         lim = (m <= TO) ? m + 1 : TO;
         fire_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lim)) : 0;
         model_txn(a, b, r1, r2, fire_at);
         drive_txn(a, b, r1, r2, fire_at);
         checks++;
         if (o_or_cnt != e_or_cnt || o_or_first != e_or_first || o_done != e_done || o_bv_bad != 0) begin
            failures++;
            $display("FAIL rnd_timing t=%0d a=%0d b=%0d: got or %0d@%0d done %0d bv_bad %0d expected or %0d@%0d done %0d",
                     t, a, b, o_or_cnt, o_or_first, o_done, o_bv_bad, e_or_cnt, e_or_first, e_done);
         end
         checks++;
         if ({timing_leak, result_leak, timeout_err, protocol_err} !== {m_tl, m_rl, m_te, m_pe}) begin
            failures++;
            $display("FAIL rnd_flags t=%0d: got %b expected %b", t,
                     {timing_leak, result_leak, timeout_err, protocol_err}, {m_tl, m_rl, m_te, m_pe});
         end
         checks++;
         if (int'(lat_one) != m_l1 || int'(lat_two) != m_l2 || int'(txn_count) != m_txn) begin
            failures++;
            $display("FAIL rnd_counts t=%0d: got lat %0d/%0d txn %0d expected %0d/%0d txn %0d",
                     t, lat_one, lat_two, txn_count, m_l1, m_l2, m_txn);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_equal_latency();
      test_skew();
      test_result_diverge();
      test_timeout();
      test_protocol_err();
      test_reset_in_drain();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
